// File: rtl/finv_table_loader.sv
// Runtime loader for the 1024-entry finv reciprocal seed table: one restoring division per entry, then x0 and x0^2 are written out.
// Optional `FINV_LOADER_CSUM_EN adds a 24-bit XOR checksum of every written (a ^ b) pair on port csum.
module finv_table_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        load,
    output logic [9:0]  addr,
    output logic [23:0] in_a,
`ifdef FINV_LOADER_CSUM_EN
    output logic [23:0] csum,
`endif
    output logic [23:0] in_b
);

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL, S_WRITE, S_DONE} state_t;

    localparam logic [24:0] Q_FIRST  = 25'h100_0000;   // q(1024) = 2^24
    localparam logic [5:0]  DIV_LAST = 6'd34;          // 35 dividend bits, 34 down to 0

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [11:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic [24:0] qprev_q, qprev_d;
    logic [9:0]  i_q, i_d;
    logic [23:0] x0_q, x0_d;
    logic [23:0] sqhi_q, sqhi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        load_q, load_d;
    logic [9:0]  addr_q, addr_d;
    logic [23:0] in_a_q, in_a_d;
    logic [23:0] in_b_q, in_b_d;
    logic [23:0] csum_q, csum_d;

    logic [12:0] divisor_c;
    logic [12:0] rem_sh_c;
    logic [12:0] diff_c;
    logic [25:0] qsum_c;
    logic [23:0] x0_c;
    logic [47:0] sq_c;

    // Shift in the next dividend bit; 2^34 has only its top bit set.
    assign divisor_c = 13'd1025 + {3'b000, i_q};
    assign rem_sh_c  = {rem_q, (cnt_q == 6'd0)};
    assign diff_c    = rem_sh_c - divisor_c;
    assign qsum_c    = {1'b0, qprev_q} + {1'b0, quo_q};
    assign x0_c      = qsum_c[24:1];
    assign sq_c      = x0_c * x0_c;

    // NOTE: every next-state signal takes its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        qprev_d = qprev_q;
        i_d     = i_q;
        x0_d    = x0_q;
        sqhi_d  = sqhi_q;
        addr_d  = addr_q;
        in_a_d  = in_a_q;
        in_b_d  = in_b_q;
        csum_d  = csum_q;
        load_d  = 1'b0;
        busy_d  = (state_q == S_DIV) || (state_q == S_MUL) || (state_q == S_WRITE);
        done_d  = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DIV;
                    i_d     = 10'd0;
                    qprev_d = Q_FIRST;
                    cnt_d   = 6'd0;
                    rem_d   = 12'd0;
                    quo_d   = 25'd0;
                    csum_d  = 24'd0;
                end
            end
            S_DIV: begin
                if (rem_sh_c >= divisor_c) begin
                    rem_d = diff_c[11:0];
                    quo_d = {quo_q[23:0], 1'b1};
                end else begin
                    rem_d = rem_sh_c[11:0];
                    quo_d = {quo_q[23:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == DIV_LAST) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                x0_d    = x0_c;
                sqhi_d  = sq_c[47:24];
                state_d = S_WRITE;
            end
            S_WRITE: begin
                load_d  = 1'b1;
                addr_d  = i_q;
                in_a_d  = sqhi_q;
                in_b_d  = x0_q;
                csum_d  = csum_q ^ sqhi_q ^ x0_q;
                qprev_d = quo_q;
                cnt_d   = 6'd0;
                rem_d   = 12'd0;
                quo_d   = 25'd0;
                if (i_q == 10'd1023) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 10'd1;
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            rem_q   <= 12'd0;
            quo_q   <= 25'd0;
            qprev_q <= Q_FIRST;
            i_q     <= 10'd0;
            x0_q    <= 24'd0;
            sqhi_q  <= 24'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= 10'd0;
            in_a_q  <= 24'd0;
            in_b_q  <= 24'd0;
            csum_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            qprev_q <= qprev_d;
            i_q     <= i_d;
            x0_q    <= x0_d;
            sqhi_q  <= sqhi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
            csum_q  <= csum_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign load = load_q;
    assign addr = addr_q;
    assign in_a = in_a_q;
    assign in_b = in_b_q;

`ifdef FINV_LOADER_CSUM_EN
    assign csum = csum_q;
`else
    logic csum_unused;
    assign csum_unused = ^csum_q;
`endif

endmodule
